// File: rtl/hdmi_cfg_seq.sv
// hdmi_cfg_seq: power-up configuration sequencer for the HDMI PHY.
// After reset (or restart) and a power-up delay it walks a register table held
// in an external synchronous ROM and issues one i2c write per entry through
// the start/busy handshake of the downstream i2c master. NACKed writes and
// missing busy responses are retried. Terminal status is reported as done/error.
//
// Ports:
//   clk_i          system clock
//   rst_i          asynchronous active-low reset
//   restart_i      one-cycle pulse, reruns the sequence (only from DONE/FAIL)
//   tbl_addr_o     table ROM address
//   tbl_data_i     table ROM data {reg, value}, valid one cycle after address
//   cmd_address_o  7-bit i2c device address (constant)
//   reg_addr_o     register byte of the current transfer
//   data_out_o     data byte of the current transfer
//   start_o        one-cycle transfer request
//   busy_i         i2c master busy
//   ack_err_i      i2c master NACK flag, valid in the cycle busy falls
//   done_o         sequence completed
//   error_o        sequence aborted on an entry that kept failing
//   fail_index_o   index of the failing entry
module hdmi_cfg_seq #(
    parameter logic [6:0]  DEV_ADDR     = 7'h39,
    parameter int          N_ENTRIES    = 32,
    parameter logic [15:0] PWR_DELAY    = 16'd50000,
    parameter logic [7:0]  GAP_CYCLES   = 8'd100,
    parameter int          MAX_RETRY    = 3,
    parameter logic [7:0]  BUSY_TIMEOUT = 8'd16,
    localparam int         IW           = (N_ENTRIES > 1) ? $clog2(N_ENTRIES) : 1
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          restart_i,
    output logic [IW-1:0] tbl_addr_o,
    input  logic [15:0]   tbl_data_i,
    output logic [6:0]    cmd_address_o,
    output logic [7:0]    reg_addr_o,
    output logic [7:0]    data_out_o,
    output logic          start_o,
    input  logic          busy_i,
    input  logic          ack_err_i,
    output logic          done_o,
    output logic          error_o,
    output logic [IW-1:0] fail_index_o
);

    localparam int            RW       = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam logic [RW-1:0] MAX_R    = RW'(MAX_RETRY);
    localparam logic [IW-1:0] LAST_IDX = IW'(N_ENTRIES - 1);
    localparam logic [15:0]   END_MARK = 16'hFFFF;

    typedef enum logic [3:0] {
        S_PWR_WAIT,
        S_FETCH,
        S_LATCH,
        S_ISSUE,
        S_WAIT_HI,
        S_WAIT_LO,
        S_GAP,
        S_DONE,
        S_FAIL
    } state_e;

    state_e        state_q;
    logic [15:0]   pwr_cnt_q;
    logic [7:0]    gap_cnt_q;
    logic [7:0]    to_cnt_q;
    logic [IW-1:0] idx_q;
    logic [IW-1:0] fail_idx_q;
    logic [RW-1:0] retry_q;
    logic          again_q;    // leaving GAP re-issues the same entry
    logic [7:0]    reg_q;
    logic [7:0]    dat_q;
    logic          start_q;
    logic          done_q;
    logic          error_q;

    // A real NACK and a busy that never rose are handled identically.
    logic nack_d;
    assign nack_d = (state_q == S_WAIT_LO && !busy_i && ack_err_i) ||
                    (state_q == S_WAIT_HI && !busy_i &&
                     to_cnt_q == BUSY_TIMEOUT - 8'd1);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q    <= S_PWR_WAIT;
            pwr_cnt_q  <= '0;
            gap_cnt_q  <= '0;
            to_cnt_q   <= '0;
            idx_q      <= '0;
            fail_idx_q <= '0;
            retry_q    <= '0;
            again_q    <= 1'b0;
            reg_q      <= '0;
            dat_q      <= '0;
            start_q    <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            start_q <= 1'b0;
            if (nack_d) begin
                if (retry_q < MAX_R) begin
                    retry_q   <= retry_q + 1'b1;
                    again_q   <= 1'b1;
                    gap_cnt_q <= '0;
                    state_q   <= S_GAP;
                end else begin
                    fail_idx_q <= idx_q;
                    error_q    <= 1'b1;
                    state_q    <= S_FAIL;
                end
            end else begin
                unique case (state_q)
                    S_PWR_WAIT: begin
                        // Counter stops at its terminal value.
                        if (pwr_cnt_q == PWR_DELAY - 16'd1) begin
                            idx_q   <= '0;
                            state_q <= S_FETCH;
                        end else begin
                            pwr_cnt_q <= pwr_cnt_q + 16'd1;
                        end
                    end
                    // Address already presented from idx_q; ROM registers it here.
                    S_FETCH: state_q <= S_LATCH;
                    S_LATCH: begin
                        if (tbl_data_i == END_MARK) begin
                            done_q  <= 1'b1;
                            state_q <= S_DONE;
                        end else begin
                            reg_q   <= tbl_data_i[15:8];
                            dat_q   <= tbl_data_i[7:0];
                            retry_q <= '0;
                            state_q <= S_ISSUE;
                        end
                    end
                    S_ISSUE: begin
                        if (!busy_i) begin
                            start_q  <= 1'b1;
                            to_cnt_q <= '0;
                            state_q  <= S_WAIT_HI;
                        end
                    end
                    S_WAIT_HI: begin
                        if (busy_i) state_q <= S_WAIT_LO;
                        else        to_cnt_q <= to_cnt_q + 8'd1;
                    end
                    S_WAIT_LO: begin
                        // NACK already handled above; only the ACK exit remains.
                        if (!busy_i) begin
                            again_q   <= 1'b0;
                            gap_cnt_q <= '0;
                            state_q   <= S_GAP;
                        end
                    end
                    S_GAP: begin
                        if (gap_cnt_q == GAP_CYCLES - 8'd1) begin
                            if (again_q) begin
                                state_q <= S_ISSUE;
                            end else if (idx_q == LAST_IDX) begin
                                // Table full: finish instead of wrapping the index.
                                done_q  <= 1'b1;
                                state_q <= S_DONE;
                            end else begin
                                idx_q   <= idx_q + 1'b1;
                                state_q <= S_FETCH;
                            end
                        end else begin
                            gap_cnt_q <= gap_cnt_q + 8'd1;
                        end
                    end
                    S_DONE, S_FAIL: begin
                        if (restart_i) begin
                            done_q     <= 1'b0;
                            error_q    <= 1'b0;
                            idx_q      <= '0;
                            fail_idx_q <= '0;
                            pwr_cnt_q  <= '0;
                            state_q    <= S_PWR_WAIT;
                        end
                    end
                    default: state_q <= S_PWR_WAIT;
                endcase
            end
        end
    end

    assign tbl_addr_o    = idx_q;
    assign cmd_address_o = DEV_ADDR;
    assign reg_addr_o    = reg_q;
    assign data_out_o    = dat_q;
    assign start_o       = start_q;
    assign done_o        = done_q;
    assign error_o       = error_q;
    assign fail_index_o  = fail_idx_q;

endmodule
